// File: rtl/rom_loader_if.sv
// rom_loader_if: byte-stream handshake in plus CPU ROM-edit port out.
interface rom_loader_if;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic edit;
  logic [7:0] unit;
  logic [7:0] code;
  logic send;
  modport slave(input rx_data, rx_valid, output rx_ready, edit, unit, code, send);
  modport master(output rx_data, rx_valid, input rx_ready, edit, unit, code, send);
endinterface

// File: rtl/rom_loader.sv
// rom_loader: framed byte stream to CPU ROM-edit writes with checksum status.
module rom_loader #(
  parameter int SEND_CYCLES = 5,
  parameter int GAP_CYCLES = 3,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input logic clk,
  input logic rst,
  rom_loader_if.slave bus,
  input logic abort,
  output logic busy,
  output logic done,
  output logic err,
  output logic [7:0] count
);
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, SETUP, WRITE, GAP, CHECK} state_t;
  state_t state_q, state_d;
  logic [7:0] unit_q, unit_d, code_q, code_d, rem_q, rem_d, sum_q, sum_d, count_q, count_d;
  logic [3:0] tmr_q, tmr_d;
  logic err_q, err_d, done_q, done_d, acc;
  assign bus.rx_ready = !(state_q inside {SETUP, WRITE, GAP});
  assign acc = bus.rx_valid && bus.rx_ready;
  assign busy = state_q != IDLE;
  assign bus.edit = busy;
  assign bus.send = state_q == WRITE;
  assign bus.unit = unit_q;
  assign bus.code = code_q;
  assign done = done_q;
  assign err = err_q;
  assign count = count_q;
  always_comb begin
    state_d = state_q;
    unit_d = unit_q;
    code_d = code_q;
    rem_d = rem_q;
    sum_d = sum_q;
    count_d = count_q;
    tmr_d = tmr_q;
    err_d = err_q;
    done_d = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (acc && bus.rx_data == HEADER) begin
          state_d = ADDR;
          err_d = 1'b0;
          count_d = 8'd0;
          sum_d = 8'd0;
        end
        ADDR: if (acc) begin
          unit_d = bus.rx_data;
          state_d = LEN;
        end
        LEN: if (acc) begin
          rem_d = bus.rx_data;
          state_d = bus.rx_data == 8'd0 ? CHECK : DATA;
        end
        DATA: if (acc) begin
          code_d = bus.rx_data;
          sum_d = sum_q + bus.rx_data;
          state_d = SETUP;
        end
        SETUP: begin
          state_d = WRITE;
          tmr_d = 4'(SEND_CYCLES - 1);
        end
        WRITE: if (tmr_q == 4'd0) begin
          state_d = GAP;
          tmr_d = 4'(GAP_CYCLES - 1);
          count_d = count_q + 8'd1;
          rem_d = rem_q - 8'd1;
          unit_d = unit_q + 8'd1;
        end else tmr_d = tmr_q - 4'd1;
        GAP: if (tmr_q == 4'd0) state_d = rem_q == 8'd0 ? CHECK : DATA;
             else tmr_d = tmr_q - 4'd1;
        CHECK: if (acc) begin
          err_d = bus.rx_data != sum_q;
          done_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      unit_q <= 8'd0;
      code_q <= 8'd0;
      rem_q <= 8'd0;
      sum_q <= 8'd0;
      count_q <= 8'd0;
      tmr_q <= 4'd0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q <= unit_d;
      code_q <= code_d;
      rem_q <= rem_d;
      sum_q <= sum_d;
      count_q <= count_d;
      tmr_q <= tmr_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
endmodule

// File: doc/rom_loader.md
# rom_loader

Upstream program loader for the CPU's instruction ROM. Accepts a framed byte stream over a valid/ready handshake and drives the CPU's `edit`/`unit`/`code`/`send` ROM-edit port. It replaces hand-driven edit sequences, writing one ROM unit per received code byte with the send-pulse timing the CPU requires. It also reports completion and checksum status.

## Interface
- `SEND_CYCLES`, default 5: clocks `send` is held high per write (1..15).
- `GAP_CYCLES`, default 3: clocks `send` is held low after each write before the next byte is accepted (1..15).
- `HEADER`, default 8'hA5: frame start byte.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader can accept a byte. A transfer occurs on a rising edge where `rx_valid && rx_ready`.
- `abort` in 1: synchronous abort request.
- `edit` out 1: to CPU `edit`; high for the whole frame body.
- `unit` out 8: to CPU `unit`; ROM address.
- `code` out 8: to CPU `code`; ROM data.
- `send` out 1: to CPU `send`; write strobe.
- `busy` out 1: a frame is in progress (any state except IDLE).
- `done` out 1: one-cycle pulse at frame end.
- `err` out 1: sticky; set on checksum mismatch or abort, cleared when the next header is accepted.
- `count` out 8: number of units written in the current or last frame.

## Operation
- Frame format: `HEADER`, start unit S, length N (0..255), N code bytes, checksum C. C is the 8-bit modulo-256 sum of the N code bytes.
- FSM states: IDLE, ADDR, LEN, DATA, SETUP, WRITE, GAP, CHECK.
- IDLE: `rx_ready`=1. A byte equal to `HEADER` moves the FSM to ADDR, clears `err` and `count`, and sets `edit`=1. Any other byte is discarded.
- ADDR: `rx_ready`=1. The accepted byte is latched as the next unit. The FSM then goes to LEN.
- LEN: `rx_ready`=1. The accepted byte is latched as the remaining count. N=0 goes to CHECK; otherwise to DATA.
- DATA: `rx_ready`=1. The accepted byte is latched into `code` and added to the running sum. The FSM then goes to SETUP.
- SETUP: one cycle. `unit` and `code` are stable, `send`=0.
- WRITE: `send`=1 for exactly `SEND_CYCLES` clocks.
- GAP: `send`=0 for `GAP_CYCLES` clocks. On entry to GAP, `count` increments, remaining decrements, and `unit` increments modulo 256 (0xFF wraps to 0x00).
  - At the end of GAP: remaining>0 returns to DATA; otherwise the FSM goes to CHECK.
- CHECK: `rx_ready`=1. On the accepted byte, `err` is set if the byte differs from the sum. `edit` is set to 0, `done` pulses, and the FSM returns to IDLE.
- `rx_ready`=0 in SETUP, WRITE and GAP.
- `unit` and `code` change only on entry to SETUP, or on unit increment at GAP entry. They are therefore constant whenever `send`=1.
- `abort` (any state except IDLE) overrides all other activity on the next edge:
  - FSM goes to IDLE; `edit`=0 and `send`=0.
  - `err`=1; `done` is not pulsed.
  - Units already written stay written.
  - `abort` in IDLE has no effect.
- Reset (asynchronous, mid-frame included) forces IDLE immediately.
  - Outputs in reset: `edit`=0, `unit`=0, `code`=0, `send`=0, `busy`=0, `done`=0, `err`=0, `count`=0.
  - `rx_ready`=1 once reset is released.

## Timing
- Header accepted at edge k: `edit`=1 and `busy`=1 from edge k.
- Data byte accepted at edge k:
  - `unit`/`code` valid from k.
  - `send` rises at k+1 and falls at k+1+`SEND_CYCLES`.
  - `rx_ready` returns at k+1+`SEND_CYCLES`+`GAP_CYCLES`.
- Per-byte cost: 2+`SEND_CYCLES`+`GAP_CYCLES` clocks, plus the handshake wait.
- Checksum accepted at edge k: `edit`=0 and `done`=1 from k; `done`=0 at k+1; `err` is valid from k.
- `rx_valid` held low stalls the FSM indefinitely in any receiving state; no timeout.

## Test plan
- Normal load: frame A5,01,02,10,30,40 with one byte per cycle.
  - Two `send` pulses, each 5 clocks wide: unit=1/code=0x10, then unit=2/code=0x30.
  - `done` pulse, `err`=0, `count`=2, `edit` low after checksum.
- Bad checksum: same frame with C=0x41.
  - Both units written; `done` pulses; `err`=1 and holds until the next A5 is accepted.
- Garbage before header: stream 00,FF,A5,05,01,7E,7E.
  - Only unit 5 is written, with code 0x7E; `err`=0.
- Boundaries:
  - Frame A5,FF,02,11,22,33 writes unit 0xFF then unit 0x00; `err`=0.
  - Frame A5,10,00,00 produces no `send`; `done` pulses; `err`=0.
- Interruptions:
  - `abort` asserted during WRITE of the second byte: `send` and `edit` drop next edge, `err`=1, no `done`, IDLE.
  - `rst` low mid-GAP: all outputs reach reset values immediately.
- Backpressure: `rx_valid` held high continuously across a 3-byte frame.
  - `rx_ready` is low for exactly 1+5+3 clocks per data byte.
  - No byte is lost or duplicated.
